// File: rtl/merge_data_if.sv
// Byte-in / sample-out bundle for merge_data.
// The slave modport is the reassembler; the master modport is the UART receiver side.
interface merge_data_if #(
  parameter int WIDTH = 16
);
  logic                    rx_valid_i;
  logic [7:0]              rx_data_i;
  logic                    rx_err_i;
  logic signed [WIDTH-1:0] sample_o;
  logic                    sample_valid_o;
  logic                    frame_err_o;
  logic                    busy_o;

  modport master (
    output rx_valid_i, rx_data_i, rx_err_i,
    input  sample_o, sample_valid_o, frame_err_o, busy_o
  );

  modport slave (
    input  rx_valid_i, rx_data_i, rx_err_i,
    output sample_o, sample_valid_o, frame_err_o, busy_o
  );
endinterface

// File: rtl/merge_data.sv
// Reassembles BYTES-byte UART frames (first byte most significant) into signed WIDTH-bit samples.
// Optional MERGE_PAD_CHECK_EN: frames whose pad bytes are non-zero are dropped as framing errors.
module merge_data #(
  parameter int WIDTH       = 16,
  parameter int BYTES       = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input logic         clk,
  input logic         rst,
  merge_data_if.slave bus
);
  localparam int SHIFT_BITS = 8 * BYTES;
  localparam int CNT_BITS   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TMR_BITS   = $clog2(TIMEOUT_CYC);

  localparam logic [CNT_BITS-1:0] LAST_BYTE = CNT_BITS'(BYTES - 1);
  localparam logic [TMR_BITS-1:0] TMR_LAST  = TMR_BITS'(TIMEOUT_CYC - 1);

  logic [SHIFT_BITS-1:0]   r_shift;
  logic [CNT_BITS-1:0]     r_byte_cnt;
  logic [TMR_BITS-1:0]     r_timer;
  logic signed [WIDTH-1:0] r_sample;
  logic                    r_sample_valid;
  logic                    r_frame_err;

  logic [SHIFT_BITS-1:0]   w_next;
  logic                    w_busy;
  logic                    w_drop;

  // Shift register contents as they will be once the current byte is taken.
  generate
    if (BYTES > 1) begin : g_shift
      assign w_next = {r_shift[SHIFT_BITS-9:0], bus.rx_data_i};
    end else begin : g_single
      assign w_next = bus.rx_data_i;
    end
  endgenerate

`ifdef MERGE_PAD_CHECK_EN
  generate
    if (SHIFT_BITS > WIDTH) begin : g_pad
      assign w_drop = |w_next[SHIFT_BITS-1:WIDTH];
    end else begin : g_nopad
      assign w_drop = 1'b0;
    end
  endgenerate
`else
  assign w_drop = 1'b0;
`endif

  assign w_busy = (r_byte_cnt != '0);

  // Priority: rx error, then byte accept, then mid-frame idle timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift        <= '0;
      r_byte_cnt     <= '0;
      r_timer        <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_frame_err    <= 1'b0;
      if (bus.rx_err_i) begin
        r_byte_cnt  <= '0;
        r_timer     <= '0;
        r_frame_err <= w_busy;
      end else if (bus.rx_valid_i) begin
        r_shift <= w_next;
        r_timer <= '0;
        if (r_byte_cnt == LAST_BYTE) begin
          r_byte_cnt <= '0;
          if (w_drop) begin
            r_frame_err <= 1'b1;
          end else begin
            r_sample       <= w_next[WIDTH-1:0];
            r_sample_valid <= 1'b1;
          end
        end else begin
          r_byte_cnt <= r_byte_cnt + CNT_BITS'(1);
        end
      end else if (w_busy) begin
        if (r_timer == TMR_LAST) begin
          r_byte_cnt  <= '0;
          r_timer     <= '0;
          r_frame_err <= 1'b1;
        end else begin
          r_timer <= r_timer + TMR_BITS'(1);
        end
      end else begin
        r_timer <= '0;
      end
    end
  end

  assign bus.sample_o       = r_sample;
  assign bus.sample_valid_o = r_sample_valid;
  assign bus.frame_err_o    = r_frame_err;
  assign bus.busy_o         = w_busy;
endmodule

// File: tb/tb_merge_data.sv
// Directed self-checking bench for merge_data (WIDTH=16, BYTES=4, TIMEOUT_CYC=100).
// Expectations for the pad-byte frame follow MERGE_PAD_CHECK_EN when it is defined.
module tb_merge_data;
  localparam int WIDTH   = 16;
  localparam int BYTES   = 4;
  localparam int TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  merge_data_if #(.WIDTH(WIDTH)) bus ();

  merge_data #(
    .WIDTH      (WIDTH),
    .BYTES      (BYTES),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int validCnt   = 0;
  int errCnt     = 0;
  int bothCnt    = 0;
  int cyc        = 0;
  int lastValidCyc = 0;
  int prevValidCyc = 0;

  // Strobe monitor: counts pulses and records when valid strobes occur.
  always @(negedge clk) begin
    cyc++;
    if (rst === 1'b0) begin
      if (bus.sample_valid_o === 1'b1) begin
        validCnt++;
        prevValidCyc = lastValidCyc;
        lastValidCyc = cyc;
      end
      if (bus.frame_err_o === 1'b1) errCnt++;
      if (bus.sample_valid_o === 1'b1 && bus.frame_err_o === 1'b1) bothCnt++;
    end
  end

  task automatic putByte(input logic [7:0] b, input logic err);
    @(negedge clk);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    bus.rx_err_i   = err;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rx_valid_i = 1'b0;
      bus.rx_err_i   = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    bus.rx_err_i   = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (bus.sample_o !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_sample got %h want 0000", bus.sample_o); end
    compared++;
    if (bus.sample_valid_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got %b want 0", bus.sample_valid_o); end
    compared++;
    if (bus.frame_err_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err got %b want 0", bus.frame_err_o); end
    compared++;
    if (bus.busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy_o); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = validCnt;
    putByte(8'h00, 1'b0);
    putByte(8'h00, 1'b0);
    compared++;
    if (bus.busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_busy1 got %b want 1", bus.busy_o); end
    putByte(8'h12, 1'b0);
    compared++;
    if (bus.busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_busy2 got %b want 1", bus.busy_o); end
    putByte(8'h34, 1'b0);
    compared++;
    if (bus.busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_busy3 got %b want 1", bus.busy_o); end
    idle(1);
    compared++;
    if (bus.sample_valid_o !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_valid got %b want 1", bus.sample_valid_o); end
    compared++;
    if (bus.sample_o !== 16'h1234) begin mismatched++; $display("[TB] FAIL b2b_sample got %h want 1234", bus.sample_o); end
    compared++;
    if (bus.busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_busy_end got %b want 0", bus.busy_o); end
    idle(1);
    compared++;
    if (bus.sample_valid_o !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_valid_single got %b want 0", bus.sample_valid_o); end
    idle(2);
    compared++;
    if (validCnt - v0 !== 1) begin mismatched++; $display("[TB] FAIL b2b_valid_count got %0d want 1", validCnt - v0); end
  endtask

  task automatic test_slow_bytes();
    int v0, e0;
    logic [7:0] seq [4];
    v0 = validCnt; e0 = errCnt;
    seq = '{8'h00, 8'h00, 8'hFF, 8'h38};
    for (int i = 0; i < 4; i++) begin
      putByte(seq[i], 1'b0);
      idle(50);
    end
    compared++;
    if (validCnt - v0 !== 1) begin mismatched++; $display("[TB] FAIL slow_valid_count got %0d want 1", validCnt - v0); end
    compared++;
    if (errCnt - e0 !== 0) begin mismatched++; $display("[TB] FAIL slow_err_count got %0d want 0", errCnt - e0); end
    compared++;
    if (bus.sample_o !== 16'hFF38) begin mismatched++; $display("[TB] FAIL slow_sample got %h want ff38", bus.sample_o); end
  endtask

  task automatic test_timeout();
    int e0, v0;
    e0 = errCnt; v0 = validCnt;
    putByte(8'h00, 1'b0);
    putByte(8'h00, 1'b0);
    idle(50);
    compared++;
    if (bus.busy_o !== 1'b1 || errCnt !== e0) begin
      mismatched++; $display("[TB] FAIL timeout_early busy %b errs %0d want busy 1 errs 0", bus.busy_o, errCnt - e0);
    end
    for (int i = 0; i < 100 && errCnt == e0; i++) @(negedge clk);
    idle(2);
    compared++;
    if (errCnt - e0 !== 1) begin mismatched++; $display("[TB] FAIL timeout_err_count got %0d want 1", errCnt - e0); end
    compared++;
    if (bus.busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_busy got %b want 0", bus.busy_o); end
    putByte(8'h00, 1'b0);
    putByte(8'h00, 1'b0);
    putByte(8'hAB, 1'b0);
    putByte(8'hCD, 1'b0);
    idle(3);
    compared++;
    if (bus.sample_o !== 16'hABCD || validCnt - v0 !== 1) begin
      mismatched++; $display("[TB] FAIL timeout_recover sample %h valids %0d want abcd 1", bus.sample_o, validCnt - v0);
    end
  endtask

  task automatic test_rx_err();
    int e0, v0;
    e0 = errCnt; v0 = validCnt;
    putByte(8'h00, 1'b0);
    putByte(8'h00, 1'b0);
    putByte(8'h12, 1'b0);
    putByte(8'h34, 1'b1);
    idle(3);
    compared++;
    if (errCnt - e0 !== 1) begin mismatched++; $display("[TB] FAIL rxerr_err_count got %0d want 1", errCnt - e0); end
    compared++;
    if (validCnt - v0 !== 0) begin mismatched++; $display("[TB] FAIL rxerr_valid_count got %0d want 0", validCnt - v0); end
    compared++;
    if (bus.sample_o !== 16'hABCD) begin mismatched++; $display("[TB] FAIL rxerr_sample_hold got %h want abcd", bus.sample_o); end
    compared++;
    if (bus.busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL rxerr_busy got %b want 0", bus.busy_o); end
    putByte(8'h00, 1'b0);
    putByte(8'h00, 1'b0);
    putByte(8'h56, 1'b0);
    putByte(8'h78, 1'b0);
    idle(3);
    compared++;
    if (bus.sample_o !== 16'h5678) begin mismatched++; $display("[TB] FAIL rxerr_recover got %h want 5678", bus.sample_o); end
  endtask

  task automatic test_idle_err();
    int e0, v0;
    e0 = errCnt; v0 = validCnt;
    putByte(8'h55, 1'b1);
    idle(3);
    compared++;
    if (errCnt - e0 !== 0 || validCnt - v0 !== 0) begin
      mismatched++; $display("[TB] FAIL idle_err errs %0d valids %0d want 0 0", errCnt - e0, validCnt - v0);
    end
  endtask

  task automatic test_pad();
    int e0, v0;
    e0 = errCnt; v0 = validCnt;
    putByte(8'h01, 1'b0);
    putByte(8'h00, 1'b0);
    putByte(8'h12, 1'b0);
    putByte(8'h34, 1'b0);
    idle(3);
`ifdef MERGE_PAD_CHECK_EN
    compared++;
    if (errCnt - e0 !== 1 || validCnt - v0 !== 0) begin
      mismatched++; $display("[TB] FAIL pad_drop errs %0d valids %0d want 1 0", errCnt - e0, validCnt - v0);
    end
    compared++;
    if (bus.sample_o !== 16'h5678) begin mismatched++; $display("[TB] FAIL pad_sample_hold got %h want 5678", bus.sample_o); end
`else
    compared++;
    if (errCnt - e0 !== 0 || validCnt - v0 !== 1) begin
      mismatched++; $display("[TB] FAIL pad_ignore errs %0d valids %0d want 0 1", errCnt - e0, validCnt - v0);
    end
    compared++;
    if (bus.sample_o !== 16'h1234) begin mismatched++; $display("[TB] FAIL pad_sample got %h want 1234", bus.sample_o); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int e0, v0;
    putByte(8'h00, 1'b0);
    putByte(8'h00, 1'b0);
    e0 = errCnt; v0 = validCnt;
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    compared++;
    if (errCnt - e0 !== 0 || validCnt - v0 !== 0) begin
      mismatched++; $display("[TB] FAIL rstmid_strobes errs %0d valids %0d want 0 0", errCnt - e0, validCnt - v0);
    end
    compared++;
    if (bus.sample_o !== 16'h0000) begin mismatched++; $display("[TB] FAIL rstmid_sample got %h want 0000", bus.sample_o); end
    compared++;
    if (bus.busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_busy got %b want 0", bus.busy_o); end
    putByte(8'h00, 1'b0);
    putByte(8'h00, 1'b0);
    putByte(8'h00, 1'b0);
    putByte(8'h07, 1'b0);
    idle(3);
    compared++;
    if (bus.sample_o !== 16'h0007) begin mismatched++; $display("[TB] FAIL rstmid_recover got %h want 0007", bus.sample_o); end
  endtask

  task automatic test_gapless_frames();
    int v0;
    logic [7:0] seq [8];
    v0 = validCnt;
    seq = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h00, 8'h00, 8'h33, 8'h44};
    for (int i = 0; i < 8; i++) putByte(seq[i], 1'b0);
    idle(3);
    compared++;
    if (validCnt - v0 !== 2) begin mismatched++; $display("[TB] FAIL gapless_count got %0d want 2", validCnt - v0); end
    compared++;
    if (lastValidCyc - prevValidCyc !== BYTES) begin
      mismatched++; $display("[TB] FAIL gapless_spacing got %0d want %0d", lastValidCyc - prevValidCyc, BYTES);
    end
    compared++;
    if (bus.sample_o !== 16'h3344) begin mismatched++; $display("[TB] FAIL gapless_sample got %h want 3344", bus.sample_o); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_slow_bytes();
    test_timeout();
    test_rx_err();
    test_idle_err();
    test_pad();
    test_reset_mid_frame();
    test_gapless_frames();
    compared++;
    if (bothCnt !== 0) begin mismatched++; $display("[TB] FAIL exclusive_strobes got %0d want 0", bothCnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
